ysyx_22051145_wbu: RTL and testbench

//  In-order write-back unit between the execute/LSU stages and ysyx_22051145_regfile.
//  - Queues EXU results in program order and attaches late load data from the LSU.
//  - Retires one completed entry per cycle onto the regfile write port (en_w/waddr/w_data).
//  - Provides a register scoreboard (rs busy) to decode so hazards stall correctly.

---
 rtl/ysyx_22051145_wbu_if.sv | 39 +++
 rtl/ysyx_22051145_wbu.sv | 190 +++++++++++++++++++
 tb/tb_ysyx_22051145_wbu.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051145_wbu_if.sv
// Handshake, regfile-write and scoreboard bundle between EXU/LSU/decode and the write-back unit.
// master = upstream pipeline side, slave = write-back unit.
interface ysyx_22051145_wbu_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        in_is_load;
    logic [63:0] in_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [63:0] lsu_data;
    logic        en_w;
    logic [4:0]  waddr;
    logic [63:0] w_data;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [63:0] rs1_fwd;
    logic [63:0] rs2_fwd;
    logic        rs1_fwd_vld;
    logic        rs2_fwd_vld;
    logic        err;

    modport master (
        output in_valid, in_rd, in_wen, in_is_load, in_data,
        output lsu_valid, lsu_data, raddr1, raddr2,
        input  in_ready, lsu_ready, en_w, waddr, w_data,
        input  rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, rs1_fwd_vld, rs2_fwd_vld, err
    );

    modport slave (
        input  in_valid, in_rd, in_wen, in_is_load, in_data,
        input  lsu_valid, lsu_data, raddr1, raddr2,
        output in_ready, lsu_ready, en_w, waddr, w_data,
        output rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, rs1_fwd_vld, rs2_fwd_vld, err
    );
endinterface

// File: rtl/ysyx_22051145_wbu.sv
// In-order write-back queue with late load fill, registered regfile write port and rs scoreboard.
// Define WBU_BYPASS_EN to forward completed results to decode instead of reporting them busy.
module ysyx_22051145_wbu #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_22051145_wbu_if.slave wbu_io
);
    logic [4:0]       rd_q   [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [DEPTH-1:0] wen_q;
    logic [DEPTH-1:0] is_load_q;
    logic [DEPTH-1:0] done_q;

    logic [AW:0]  head_q, head_d;
    logic [AW:0]  tail_q, tail_d;
    logic         en_w_q, en_w_d;
    logic [4:0]   waddr_q, waddr_d;
    logic [63:0]  w_data_q, w_data_d;
    logic         err_q, err_d;

    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic [AW-1:0]    head_idx;
    logic [AW-1:0]    tail_idx;
    logic [DEPTH-1:0] entry_vld;
    logic             push;
    logic             retire;
    logic             ld_found;
    logic [AW-1:0]    ld_idx;
    logic             lsu_acc;

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];
    assign count    = tail_q - head_q;
    assign empty    = (head_q == tail_q);
    assign full     = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);

    // A slot is live when its distance from head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vld
            logic [AW-1:0] offs;
            assign offs          = AW'(gi) - head_idx;
            assign entry_vld[gi] = ({1'b0, offs} < count);
        end
    endgenerate

    always_comb begin
        ld_found = 1'b0;
        ld_idx   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entry_vld[head_idx + AW'(k)] && is_load_q[head_idx + AW'(k)] &&
                !done_q[head_idx + AW'(k)]) begin
                ld_found = 1'b1;
                ld_idx   = head_idx + AW'(k);
            end
        end
    end

    assign push    = wbu_io.in_valid && !full;
    assign lsu_acc = wbu_io.lsu_valid && ld_found;
    assign retire  = !empty && done_q[head_idx];

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        en_w_d   = 1'b0;
        waddr_d  = waddr_q;
        w_data_d = w_data_q;
        err_d    = err_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (retire) begin
            head_d   = head_q + 1'b1;
            en_w_d   = wen_q[head_idx];
            waddr_d  = rd_q[head_idx];
            w_data_d = data_q[head_idx];
        end
        if (wbu_io.lsu_valid && !ld_found) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            en_w_q   <= 1'b0;
            waddr_q  <= '0;
            w_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            en_w_q   <= en_w_d;
            waddr_q  <= waddr_d;
            w_data_q <= w_data_d;
            err_q    <= err_d;
        end
    end

    // Payload needs no reset: liveness comes only from the pointers. The enqueue
    // slot is never live, so it cannot collide with the load being filled.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_idx]      <= wbu_io.in_rd;
            wen_q[tail_idx]     <= wbu_io.in_wen && (wbu_io.in_rd != 5'd0);
            is_load_q[tail_idx] <= wbu_io.in_is_load;
            done_q[tail_idx]    <= !wbu_io.in_is_load;
            data_q[tail_idx]    <= wbu_io.in_data;
        end
        if (lsu_acc) begin
            data_q[ld_idx] <= wbu_io.lsu_data;
            done_q[ld_idx] <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [4:0]  raddr;
            logic        busy;
            logic        fwd_vld;
            logic [63:0] fwd;

            assign raddr = (gi == 0) ? wbu_io.raddr1 : wbu_io.raddr2;
`ifdef WBU_BYPASS_EN
            logic          y_found;
            logic          y_done;
            logic [63:0]   y_data;
            logic [AW-1:0] sidx;

            // Walk oldest to youngest so the last hit is the youngest producer;
            // the output stage is older than every queued entry.
            always_comb begin
                y_found = 1'b0;
                y_done  = 1'b0;
                y_data  = '0;
                sidx    = '0;
                if (en_w_q && (waddr_q == raddr)) begin
                    y_found = 1'b1;
                    y_done  = 1'b1;
                    y_data  = w_data_q;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    sidx = head_idx + AW'(k);
                    if (entry_vld[sidx] && wen_q[sidx] && (rd_q[sidx] == raddr)) begin
                        y_found = 1'b1;
                        y_done  = done_q[sidx];
                        y_data  = data_q[sidx];
                    end
                end
                busy    = (raddr != 5'd0) && y_found && !y_done;
                fwd_vld = (raddr != 5'd0) && y_found && y_done;
                fwd     = fwd_vld ? y_data : 64'd0;
            end
`else
            logic hit;

            always_comb begin
                hit = en_w_q && (waddr_q == raddr);
                for (int k = 0; k < DEPTH; k++) begin
                    if (entry_vld[k] && wen_q[k] && (rd_q[k] == raddr)) begin
                        hit = 1'b1;
                    end
                end
                busy    = (raddr != 5'd0) && hit;
                fwd_vld = 1'b0;
                fwd     = 64'd0;
            end
`endif
        end
    endgenerate

    assign wbu_io.in_ready    = !full;
    assign wbu_io.lsu_ready   = ld_found;
    assign wbu_io.en_w        = en_w_q;
    assign wbu_io.waddr       = waddr_q;
    assign wbu_io.w_data      = w_data_q;
    assign wbu_io.err         = err_q;
    assign wbu_io.rs1_busy    = g_port[0].busy;
    assign wbu_io.rs2_busy    = g_port[1].busy;
    assign wbu_io.rs1_fwd_vld = g_port[0].fwd_vld;
    assign wbu_io.rs2_fwd_vld = g_port[1].fwd_vld;
    assign wbu_io.rs1_fwd     = g_port[0].fwd;
    assign wbu_io.rs2_fwd     = g_port[1].fwd;
endmodule

// File: tb/tb_ysyx_22051145_wbu.sv
// Directed bench for the write-back unit: latency, load ordering, x0, full/wrap, err, reset, bypass.
module tb_ysyx_22051145_wbu;
`ifdef WBU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    ysyx_22051145_wbu_if wbu_if ();

    ysyx_22051145_wbu #(.DEPTH(4), .AW(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .wbu_io (wbu_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_in();
        wbu_if.in_valid   = 1'b0;
        wbu_if.in_rd      = 5'd0;
        wbu_if.in_wen     = 1'b0;
        wbu_if.in_is_load = 1'b0;
        wbu_if.in_data    = 64'd0;
        wbu_if.lsu_valid  = 1'b0;
        wbu_if.lsu_data   = 64'd0;
    endtask

    task automatic push(input logic [4:0] rd, input logic ld, input logic [63:0] data);
        wbu_if.in_valid   = 1'b1;
        wbu_if.in_rd      = rd;
        wbu_if.in_wen     = 1'b1;
        wbu_if.in_is_load = ld;
        wbu_if.in_data    = data;
    endtask

    task automatic lsu(input logic [63:0] data);
        wbu_if.lsu_valid = 1'b1;
        wbu_if.lsu_data  = data;
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] rd, input logic [63:0] data);
        check({tag, " en_w"}, wbu_if.en_w, 1'b1);
        check({tag, " waddr"}, wbu_if.waddr, rd);
        check({tag, " w_data"}, wbu_if.w_data, data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_in();
        wbu_if.raddr1 = 5'd0;
        wbu_if.raddr2 = 5'd0;
        repeat (2) @(posedge clk);
        settle();
        check("rst en_w", wbu_if.en_w, 1'b0);
        check("rst waddr", wbu_if.waddr, 5'd0);
        check("rst w_data", wbu_if.w_data, 64'd0);
        check("rst in_ready", wbu_if.in_ready, 1'b1);
        check("rst lsu_ready", wbu_if.lsu_ready, 1'b0);
        check("rst err", wbu_if.err, 1'b0);
        next_cyc();
        rst = 1'b0;

        // ALU result, empty queue: write at t+2
        next_cyc();
        wbu_if.raddr1 = 5'd5;
        push(5'd5, 1'b0, 64'h1234);
        settle();
        check("alu t busy", wbu_if.rs1_busy, 1'b0);
        check("alu t en_w", wbu_if.en_w, 1'b0);
        next_cyc();
        idle_in();
        settle();
        check("alu t+1 busy", wbu_if.rs1_busy, !BYP);
        check("alu t+1 fwd_vld", wbu_if.rs1_fwd_vld, BYP);
        check("alu t+1 en_w", wbu_if.en_w, 1'b0);
        next_cyc();
        settle();
        expect_wr("alu t+2", 5'd5, 64'h1234);
        check("alu t+2 busy", wbu_if.rs1_busy, !BYP);
        next_cyc();
        settle();
        check("alu t+3 en_w", wbu_if.en_w, 1'b0);
        check("alu t+3 busy", wbu_if.rs1_busy, 1'b0);
        check("alu t+3 waddr hold", wbu_if.waddr, 5'd5);

        // Load x3 then ALU x4; load data three cycles later
        next_cyc();
        wbu_if.raddr2 = 5'd3;
        push(5'd3, 1'b1, 64'd0);
        next_cyc();
        push(5'd4, 1'b0, 64'd7);
        settle();
        check("ld a+1 lsu_ready", wbu_if.lsu_ready, 1'b1);
        check("ld a+1 rs2_busy", wbu_if.rs2_busy, 1'b1);
        next_cyc();
        idle_in();
        settle();
        check("ld a+2 en_w", wbu_if.en_w, 1'b0);
        next_cyc();
        lsu(64'hAB);
        settle();
        check("ld a+3 en_w", wbu_if.en_w, 1'b0);
        check("ld a+3 lsu_ready", wbu_if.lsu_ready, 1'b1);
        next_cyc();
        idle_in();
        settle();
        check("ld a+4 en_w", wbu_if.en_w, 1'b0);
        check("ld a+4 lsu_ready", wbu_if.lsu_ready, 1'b0);
        next_cyc();
        settle();
        expect_wr("ld a+5 x3", 5'd3, 64'hAB);
        next_cyc();
        settle();
        expect_wr("ld a+6 x4", 5'd4, 64'd7);

        // x0 destination never writes and never reports busy
        next_cyc();
        wbu_if.raddr1 = 5'd0;
        push(5'd0, 1'b0, 64'h99);
        next_cyc();
        idle_in();
        settle();
        check("x0 busy", wbu_if.rs1_busy, 1'b0);
        next_cyc();
        settle();
        check("x0 en_w", wbu_if.en_w, 1'b0);
        check("x0 waddr", wbu_if.waddr, 5'd0);

        // Fill with four loads, reject a push while full, then drain with wrap
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            push(5'(10 + i), 1'b1, 64'd0);
        end
        next_cyc();
        push(5'd20, 1'b0, 64'h77);
        lsu(64'hA0);
        settle();
        check("full c+4 in_ready", wbu_if.in_ready, 1'b0);
        next_cyc();
        idle_in();
        settle();
        check("full c+5 in_ready", wbu_if.in_ready, 1'b0);
        check("full c+5 en_w", wbu_if.en_w, 1'b0);
        next_cyc();
        push(5'd14, 1'b0, 64'hE);
        settle();
        check("full c+6 in_ready", wbu_if.in_ready, 1'b1);
        expect_wr("full c+6 x10", 5'd10, 64'hA0);
        next_cyc();
        idle_in();
        lsu(64'hA1);
        settle();
        check("full c+7 in_ready", wbu_if.in_ready, 1'b0);
        check("full c+7 en_w", wbu_if.en_w, 1'b0);
        next_cyc();
        lsu(64'hA2);
        settle();
        check("full c+8 en_w", wbu_if.en_w, 1'b0);
        next_cyc();
        lsu(64'hA3);
        push(5'd15, 1'b0, 64'hF);
        settle();
        expect_wr("full c+9 x11", 5'd11, 64'hA1);
        next_cyc();
        idle_in();
        settle();
        expect_wr("full c+10 x12", 5'd12, 64'hA2);
        next_cyc();
        settle();
        expect_wr("full c+11 x13", 5'd13, 64'hA3);
        next_cyc();
        settle();
        expect_wr("full c+12 x14", 5'd14, 64'hE);
        next_cyc();
        settle();
        expect_wr("full c+13 x15", 5'd15, 64'hF);
        next_cyc();
        settle();
        check("full c+14 en_w", wbu_if.en_w, 1'b0);
        check("full c+14 in_ready", wbu_if.in_ready, 1'b1);
        check("full c+14 err", wbu_if.err, 1'b0);

        // Stray load data sets sticky err and writes nothing
        next_cyc();
        lsu(64'hDEAD);
        settle();
        check("err lsu_ready", wbu_if.lsu_ready, 1'b0);
        check("err before", wbu_if.err, 1'b0);
        next_cyc();
        idle_in();
        settle();
        check("err set", wbu_if.err, 1'b1);
        check("err en_w", wbu_if.en_w, 1'b0);
        next_cyc();
        settle();
        check("err sticky", wbu_if.err, 1'b1);
        check("err en_w later", wbu_if.en_w, 1'b0);

        // Asynchronous reset with entries queued
        next_cyc();
        wbu_if.raddr1 = 5'd7;
        push(5'd7, 1'b1, 64'd0);
        next_cyc();
        push(5'd8, 1'b0, 64'h88);
        next_cyc();
        idle_in();
        settle();
        check("mid busy x7", wbu_if.rs1_busy, 1'b1);
        check("mid lsu_ready", wbu_if.lsu_ready, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst en_w", wbu_if.en_w, 1'b0);
        check("arst in_ready", wbu_if.in_ready, 1'b1);
        check("arst err", wbu_if.err, 1'b0);
        check("arst lsu_ready", wbu_if.lsu_ready, 1'b0);
        check("arst busy x7", wbu_if.rs1_busy, 1'b0);
        next_cyc();
        rst = 1'b0;
        next_cyc();
        settle();
        check("post rst en_w", wbu_if.en_w, 1'b0);
        check("post rst in_ready", wbu_if.in_ready, 1'b1);

        // Forwarding: done ALU x9 behind a blocking load, then a younger pending load x9
        next_cyc();
        wbu_if.raddr2 = 5'd9;
        push(5'd1, 1'b1, 64'd0);
        next_cyc();
        push(5'd9, 1'b0, 64'h55);
        next_cyc();
        push(5'd9, 1'b1, 64'd0);
        settle();
        check("byp rs2_busy", wbu_if.rs2_busy, !BYP);
        check("byp rs2_fwd_vld", wbu_if.rs2_fwd_vld, BYP);
        check("byp rs2_fwd", wbu_if.rs2_fwd, BYP ? 64'h55 : 64'd0);
        next_cyc();
        idle_in();
        settle();
        check("byp ld rs2_busy", wbu_if.rs2_busy, 1'b1);
        check("byp ld rs2_fwd_vld", wbu_if.rs2_fwd_vld, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
